// File: rtl/bypass_source_pkg.sv
// Shared pipeline types for the dual-issue forwarding source.
// Issue, execute-bypass and stage payloads plus slot/stage constants.
package bypass_source_pkg;

   localparam int unsigned NUM_SLOTS  = 2;
   localparam int unsigned NUM_STAGES = 3;
   localparam int unsigned STAGE_E    = 0;
   localparam int unsigned STAGE_M1   = 1;
   localparam int unsigned STAGE_M2   = 2;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CREG_W     = 5;
   localparam int unsigned LOADS_W    = 3;

   typedef logic [CREG_W-1:0] creg_addr_t;

   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memtoreg;
      creg_addr_t rdst;
   } fwd_issue_t;

   typedef struct packed {
      creg_addr_t rdst;
      logic       regwrite;
   } bypass_execute_t;

   typedef struct packed {
      logic              regwrite;
      logic              memtoreg;
      creg_addr_t        rdst;
      logic [DATA_W-1:0] data;
   } bypass_input_t;

   typedef bypass_input_t [NUM_SLOTS-1:0] stage_slots_t;

   // Number of slots in a stage carrying a load.
   function automatic logic [LOADS_W-1:0] count_loads(input stage_slots_t slots);
      logic [LOADS_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cnt = cnt + LOADS_W'(slots[i].memtoreg);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/bypass_source_fwd_stage_reg.sv
// One pipeline stage register holding both issue slots.
// Priority: reset, then hold, then clear (bubble), then load.
module fwd_stage_reg
   import bypass_source_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         clear,
   input  stage_slots_t load_in,
   output stage_slots_t slots_out
);

   stage_slots_t slots_d;
   stage_slots_t slots_q;

   always_comb begin
      slots_d = slots_q;
      if (!hold) begin
         slots_d = clear ? '0 : load_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slots_q <= '0;
      end else begin
         slots_q <= slots_d;
      end
   end

   assign slots_out = slots_q;

endmodule

// File: rtl/bypass_source.sv
// Tracks destination/control of the dual-issue pair through E, M1 and M2
// and presents per-stage bypass sources plus an in-flight load count.
module bypass_source
   import bypass_source_pkg::*;
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                stall,
   input  logic                                flush,
   input  fwd_issue_t [NUM_SLOTS-1:0]          issue_in,
   input  logic [NUM_SLOTS-1:0][DATA_W-1:0]    exe_result,
   input  logic [NUM_SLOTS-1:0][DATA_W-1:0]    mem_data,
   output bypass_execute_t [NUM_SLOTS-1:0]     dataEnxt_out,
   output bypass_input_t [NUM_SLOTS-1:0]       dataE_out,
   output bypass_input_t [NUM_SLOTS-1:0]       dataM1_out,
   output bypass_input_t [NUM_SLOTS-1:0]       dataM2_out,
   output logic [LOADS_W-1:0]                  loads_inflight
);

   stage_slots_t            stage_in [NUM_STAGES];
   stage_slots_t            stage_q  [NUM_STAGES];
   logic [NUM_STAGES-1:0]   stage_clear;
   logic [LOADS_W-1:0]      loads_enter;
   logic [LOADS_W-1:0]      loads_leave;
   logic [LOADS_W-1:0]      loads_d;
   logic [LOADS_W-1:0]      loads_q;
   logic                    e_data_unused;

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      fwd_stage_reg u_stage (
         .clk       (clk),
         .reset     (reset),
         .hold      (stall),
         .clear     (stage_clear[s]),
         .load_in   (stage_in[s]),
         .slots_out (stage_q[s])
      );
   end

   // Stage inputs and bypass outputs; r0 never reports a write.
   always_comb begin
      stage_clear          = '0;
      stage_clear[STAGE_E] = flush;
      stage_in[STAGE_E]    = '0;
      stage_in[STAGE_M1]   = '0;
      stage_in[STAGE_M2]   = '0;
      dataEnxt_out         = '0;
      dataE_out            = '0;
      dataM1_out           = '0;
      dataM2_out           = '0;
      e_data_unused        = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         dataEnxt_out[i].rdst     = issue_in[i].rdst;
         dataEnxt_out[i].regwrite = issue_in[i].valid & issue_in[i].regwrite &
                                    (issue_in[i].rdst != '0) & ~flush;

         stage_in[STAGE_E][i].regwrite = issue_in[i].valid & issue_in[i].regwrite &
                                         (issue_in[i].rdst != '0);
         stage_in[STAGE_E][i].memtoreg = issue_in[i].valid & issue_in[i].memtoreg;
         stage_in[STAGE_E][i].rdst     = issue_in[i].rdst;

         stage_in[STAGE_M1][i]      = stage_q[STAGE_E][i];
         stage_in[STAGE_M1][i].data = exe_result[i];
         stage_in[STAGE_M2][i]      = stage_q[STAGE_M1][i];

         dataE_out[i]      = stage_q[STAGE_E][i];
         dataE_out[i].data = exe_result[i];
         dataM1_out[i]     = stage_q[STAGE_M1][i];

         // Loads resolve in M2: the value comes from memory, no further stall.
         dataM2_out[i]          = stage_q[STAGE_M2][i];
         dataM2_out[i].memtoreg = 1'b0;
         dataM2_out[i].data     = stage_q[STAGE_M2][i].memtoreg ? mem_data[i]
                                                                : stage_q[STAGE_M2][i].data;

         e_data_unused = e_data_unused ^ (^stage_q[STAGE_E][i].data);
      end
   end

   always_comb begin
      loads_enter = flush ? '0 : count_loads(stage_in[STAGE_E]);
      loads_leave = count_loads(stage_q[STAGE_M2]);
      loads_d     = loads_q;
      if (!stall) begin
         loads_d = loads_q + loads_enter - loads_leave;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         loads_q <= '0;
      end else begin
         loads_q <= loads_d;
      end
   end

   assign loads_inflight = loads_q;

endmodule

// File: tb/tb_bypass_source.sv
// Directed checks of the bypass source pipeline with hand-computed values.
module tb_bypass_source;
   import bypass_source_pkg::*;

   logic                              clk;
   logic                              reset;
   logic                              stall;
   logic                              flush;
   fwd_issue_t [NUM_SLOTS-1:0]        issue_in;
   logic [NUM_SLOTS-1:0][DATA_W-1:0]  exe_result;
   logic [NUM_SLOTS-1:0][DATA_W-1:0]  mem_data;
   bypass_execute_t [NUM_SLOTS-1:0]   dataEnxt_out;
   bypass_input_t [NUM_SLOTS-1:0]     dataE_out;
   bypass_input_t [NUM_SLOTS-1:0]     dataM1_out;
   bypass_input_t [NUM_SLOTS-1:0]     dataM2_out;
   logic [LOADS_W-1:0]                loads_inflight;

   int checks;
   int errors;

   bypass_source dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .issue_in       (issue_in),
      .exe_result     (exe_result),
      .mem_data       (mem_data),
      .dataEnxt_out   (dataEnxt_out),
      .dataE_out      (dataE_out),
      .dataM1_out     (dataM1_out),
      .dataM2_out     (dataM2_out),
      .loads_inflight (loads_inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic fwd_issue_t fi(input logic v, input logic rw, input logic mt,
                                     input creg_addr_t rd);
      fi = '{valid: v, regwrite: rw, memtoreg: mt, rdst: rd};
   endfunction

   function automatic bypass_input_t bi(input logic rw, input logic mt, input creg_addr_t rd,
                                        input logic [DATA_W-1:0] d);
      bi = '{regwrite: rw, memtoreg: mt, rdst: rd, data: d};
   endfunction

   function automatic bypass_execute_t bx(input creg_addr_t rd, input logic rw);
      bx = '{rdst: rd, regwrite: rw};
   endfunction

   // Advance one clock, then settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < NUM_SLOTS; i++) begin
         check($sformatf("%s_e%0d", tag, i), 64'(dataE_out[i]), 64'(0));
         check($sformatf("%s_m1_%0d", tag, i), 64'(dataM1_out[i]), 64'(0));
         check($sformatf("%s_m2_%0d", tag, i), 64'(dataM2_out[i]), 64'(0));
      end
      check($sformatf("%s_loads", tag), 64'(loads_inflight), 64'(0));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      issue_in   = '0;
      exe_result = '0;
      mem_data   = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_all_zero("reset");

      // Simple ALU op through the pipe, slot 0.
      issue_in[0] = fi(1'b1, 1'b1, 1'b0, 5'd5);
      #1;
      check("alu_enxt", 64'(dataEnxt_out[0]), 64'(bx(5'd5, 1'b1)));
      tick();
      issue_in      = '0;
      exe_result[0] = 32'h1234;
      #1;
      check("alu_e", 64'(dataE_out[0]), 64'(bi(1'b1, 1'b0, 5'd5, 32'h1234)));
      tick();
      exe_result = '0;
      #1;
      check("alu_m1", 64'(dataM1_out[0]), 64'(bi(1'b1, 1'b0, 5'd5, 32'h1234)));
      check("alu_e_empty", 64'(dataE_out[0]), 64'(0));
      tick();
      check("alu_m2", 64'(dataM2_out[0]), 64'(bi(1'b1, 1'b0, 5'd5, 32'h1234)));

      // Load in slot 1 with data returning at M2.
      issue_in[1] = fi(1'b1, 1'b1, 1'b1, 5'd7);
      tick();
      issue_in = '0;
      #1;
      check("ld_e", 64'(dataE_out[1]), 64'(bi(1'b1, 1'b1, 5'd7, 32'h0)));
      check("ld_cnt_e", 64'(loads_inflight), 64'(1));
      tick();
      check("ld_m1", 64'(dataM1_out[1]), 64'(bi(1'b1, 1'b1, 5'd7, 32'h0)));
      check("ld_cnt_m1", 64'(loads_inflight), 64'(1));
      tick();
      mem_data[1] = 32'hCAFE;
      #1;
      check("ld_m2", 64'(dataM2_out[1]), 64'(bi(1'b1, 1'b0, 5'd7, 32'hCAFE)));
      check("ld_cnt_m2", 64'(loads_inflight), 64'(1));
      tick();
      mem_data = '0;
      #1;
      check("ld_cnt_done", 64'(loads_inflight), 64'(0));

      // Write to r0 never reports regwrite.
      issue_in[0] = fi(1'b1, 1'b1, 1'b0, 5'd0);
      #1;
      check("r0_enxt", 64'(dataEnxt_out[0]), 64'(bx(5'd0, 1'b0)));
      tick();
      issue_in = '0;
      #1;
      check("r0_e", 64'(dataE_out[0]), 64'(0));
      tick();
      check("r0_m1", 64'(dataM1_out[0]), 64'(0));
      tick();
      check("r0_m2", 64'(dataM2_out[0]), 64'(0));

      // Flush of a valid pair while an older op keeps advancing.
      issue_in[0] = fi(1'b1, 1'b1, 1'b0, 5'd3);
      tick();
      issue_in[0]   = fi(1'b1, 1'b1, 1'b0, 5'd9);
      issue_in[1]   = fi(1'b1, 1'b1, 1'b1, 5'd10);
      flush         = 1'b1;
      exe_result[0] = 32'h55;
      #1;
      check("fl_enxt0", 64'(dataEnxt_out[0]), 64'(bx(5'd9, 1'b0)));
      check("fl_enxt1", 64'(dataEnxt_out[1]), 64'(bx(5'd10, 1'b0)));
      tick();
      flush      = 1'b0;
      issue_in   = '0;
      exe_result = '0;
      #1;
      check("fl_e0", 64'(dataE_out[0]), 64'(0));
      check("fl_e1", 64'(dataE_out[1]), 64'(0));
      check("fl_m1", 64'(dataM1_out[0]), 64'(bi(1'b1, 1'b0, 5'd3, 32'h55)));
      check("fl_cnt", 64'(loads_inflight), 64'(0));
      tick();
      check("fl_m2", 64'(dataM2_out[0]), 64'(bi(1'b1, 1'b0, 5'd3, 32'h55)));

      // Stall with a load in M2 (slot 0) and one in E (slot 1).
      issue_in[0] = fi(1'b1, 1'b1, 1'b1, 5'd4);
      tick();
      issue_in = '0;
      tick();
      issue_in[1] = fi(1'b1, 1'b1, 1'b1, 5'd6);
      tick();
      issue_in    = '0;
      issue_in[0] = fi(1'b1, 1'b1, 1'b1, 5'd11);
      mem_data[0] = 32'hBEEF;
      stall       = 1'b1;
      for (int c = 0; c < 3; c++) begin
         flush = (c == 1);
         #1;
         check($sformatf("st_e1_%0d", c), 64'(dataE_out[1]), 64'(bi(1'b1, 1'b1, 5'd6, 32'h0)));
         check($sformatf("st_e0_%0d", c), 64'(dataE_out[0]), 64'(0));
         check($sformatf("st_m1_%0d", c), 64'(dataM1_out[1]), 64'(0));
         check($sformatf("st_m2_%0d", c), 64'(dataM2_out[0]),
               64'(bi(1'b1, 1'b0, 5'd4, 32'hBEEF)));
         check($sformatf("st_cnt_%0d", c), 64'(loads_inflight), 64'(2));
         tick();
      end
      stall    = 1'b0;
      flush    = 1'b0;
      issue_in = '0;
      #1;
      check("st_cnt_hold", 64'(loads_inflight), 64'(2));
      tick();
      mem_data = '0;
      #1;
      check("st_cnt_after", 64'(loads_inflight), 64'(1));
      check("st_m1_after", 64'(dataM1_out[1]), 64'(bi(1'b1, 1'b1, 5'd6, 32'h0)));

      // Reset with two loads in flight, stall and flush also active.
      issue_in[0] = fi(1'b1, 1'b1, 1'b1, 5'd12);
      tick();
      check("rs_cnt_pre", 64'(loads_inflight), 64'(2));
      reset = 1'b1;
      stall = 1'b1;
      flush = 1'b1;
      tick();
      reset    = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      issue_in = '0;
      #1;
      check_all_zero("rs");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bypass_source.md
BYPASS_SOURCE -- requirements
Module: bypass_source

Interface
REQ-001 SHALL have no parameters; slot count fixed at 2 (dual issue).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 stall  in  1  freeze E, M1 and M2 registers.
REQ-005 flush  in  1  kill the instructions entering E this cycle.
REQ-006 issue_in[1:0]  in  fwd_issue_t  {valid, regwrite, memtoreg, rdst(5)} of the pair leaving issue.
REQ-007 exe_result[1:0]  in  32  ALU result of the current E slots (combinational from execute).
REQ-008 mem_data[1:0]  in  32  load data for the current M2 slots.
REQ-009 dataEnxt_out[1:0]  out  bypass_execute_t  {rdst, regwrite} of the pair about to enter E.
REQ-010 dataE_out[1:0], dataM1_out[1:0], dataM2_out[1:0]  out  bypass_input_t  {regwrite, memtoreg, rdst, data} per stage.
REQ-011 loads_inflight  out  3  count of valid memtoreg entries in E, M1 and M2 (0..6).

Function
REQ-012 dataEnxt_out[i] SHALL be combinational: rdst=issue_in[i].rdst; regwrite=issue_in[i].valid & regwrite & (rdst!=0) & ~flush.
REQ-013 Each stage register (E, M1, M2) SHALL hold, per slot: regwrite, memtoreg, rdst; M1 and M2 also hold 32-bit data.
REQ-014 When stall=0 and flush=0, E SHALL load issue_in with regwrite qualified as in REQ-012 and memtoreg qualified by valid.
REQ-015 When stall=0 and flush=1, E SHALL load all-zero (bubble); M1 and M2 advance normally.
REQ-016 When stall=0, M1 SHALL load E with data=exe_result[i]; M2 SHALL load M1 unchanged.
REQ-017 When stall=1, all stage registers SHALL hold; flush is ignored (issue holds its pair).
REQ-018 dataE_out[i].data SHALL be exe_result[i]; dataM1_out[i].data the M1 register data.
REQ-019 dataM2_out[i] SHALL present data=mem_data[i] and memtoreg=0 when the M2 entry has memtoreg=1, else the registered data with memtoreg=0.
REQ-020 An entry with rdst=0 SHALL never present regwrite=1 at any stage.
REQ-021 A memtoreg entry SHALL keep memtoreg=1 in dataE_out and dataM1_out (consumer stalls on it).
REQ-022 loads_inflight SHALL be a registered counter: +number of memtoreg entries loaded into E, -number of memtoreg entries leaving M2, updated only when stall=0; simultaneous enter/leave net in one cycle.
REQ-023 Slot order SHALL be preserved: slot 0 of a pair stays slot 0 in every stage.
REQ-024 Output latency: issue -> dataE_out 1 cycle, -> dataM1_out 2, -> dataM2_out 3 (no stalls).

Reset
REQ-025 On reset=1 at a clock edge, all stage registers and loads_inflight SHALL clear to 0, overriding stall and flush.
REQ-026 After reset, every dataE/M1/M2_out SHALL read regwrite=0, memtoreg=0, rdst=0; data of dataM1/M2 SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL drop all in-flight entries with no partial update.

Structure
REQ-028 fwd_issue_t SHALL be added to the shared pipes package beside bypass_input_t and bypass_execute_t; creg_addr_t reused for rdst.
REQ-029 One sub-module fwd_stage_reg (one stage, two slots, hold/clear/load controls) SHALL be instanced three times.
REQ-030 Stage count and slot count SHALL be package constants, not literals.

Verification
REQ-031 Issue slot0 {valid, regwrite, rdst=5}, exe_result[0]=0x1234 -> dataE_out[0] rdst=5 regwrite=1 at cycle 1; dataM1_out[0].data=0x1234 at cycle 2; dataM2_out[0] same at cycle 3.
REQ-032 Issue load slot1 rdst=7 memtoreg, mem_data[1]=0xCAFE at cycle 3 -> dataM1_out[1].memtoreg=1; dataM2_out[1] data=0xCAFE memtoreg=0; loads_inflight 1,1,1 then 0.
REQ-033 Issue rdst=0 regwrite -> dataEnxt_out and all stage outputs regwrite=0.
REQ-034 flush with valid pair -> dataEnxt_out regwrite=0, next-cycle dataE_out all zero, M1/M2 still advance.
REQ-035 stall for 3 cycles with loads in E and M2 -> all outputs and loads_inflight frozen; flush during stall has no effect.
REQ-036 reset while 2 loads in flight -> next cycle all outputs zero, loads_inflight=0.
